issue_ctrl: RTL and testbench



---
 rtl/issue_ctrl.sv | 146 ++++++++++++++
 tb/tb_issue_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - fetch-to-issue sequencing FIFO with resource and spacing gate
// Optional direct fetch-to-issue bypass when the queue is empty: define ISSUE_BYPASS_EN.
module issue_ctrl #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             has_misbranch,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_inst,
  input  logic [31:0]      fetch_pc,
  input  logic             fetch_has_jump,
  output logic             fetch_ready,
  input  logic             rob_avail,
  input  logic             rs_avail,
  input  logic             slb_avail,
  output logic             can_issue,
  output logic [31:0]      inst,
  output logic [31:0]      pc,
  output logic             has_jump,
  output logic [PTR_W:0]   q_count
);

  localparam int               GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [PTR_W:0]   FULL     = (PTR_W+1)'(DEPTH);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 1);

  typedef enum logic {S_IDLE, S_GAP} state_t;

  state_t           state, state_next;
  logic [GAP_W-1:0] gap_cnt, gap_next;
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count;
  logic [31:0]      mem_inst [DEPTH];
  logic [31:0]      mem_pc   [DEPTH];
  logic             mem_jump [DEPTH];
  logic             push, pop, take_fetch;
  logic             head_ok, fetch_ok;

  function automatic logic needs_slb(input logic [6:0] opcode);
    return (opcode == 7'b0000011) || (opcode == 7'b0100011);
  endfunction

  assign fetch_ready = (count != FULL);
  assign q_count     = count;
  assign head_ok     = rob_avail && (needs_slb(mem_inst[head][6:0]) ? slb_avail : rs_avail);

`ifdef ISSUE_BYPASS_EN
  assign fetch_ok = rob_avail && (needs_slb(fetch_inst[6:0]) ? slb_avail : rs_avail);
`else
  assign fetch_ok = 1'b0;
`endif

  always_comb begin
    state_next = state;
    gap_next   = gap_cnt;
    pop        = 1'b0;
    take_fetch = 1'b0;
    push       = 1'b0;
    if (rdy && !has_misbranch) begin
      case (state)
        S_IDLE: begin
          if (count != '0 && head_ok) begin
            pop = 1'b1;
          end else if (count == '0 && fetch_valid && fetch_ok) begin
            take_fetch = 1'b1;
          end
          if (pop || take_fetch) begin
            gap_next = GAP_LOAD;
            if (GAP > 1) state_next = S_GAP;
          end
        end
        S_GAP: begin
          gap_next = (gap_cnt != '0) ? gap_cnt - GAP_W'(1) : '0;
          if (gap_cnt <= GAP_W'(1)) state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
      // A bypassed instruction goes straight to the outputs and never occupies a slot.
      push = fetch_valid && fetch_ready && !take_fetch;
    end else if (rdy) begin
      state_next = S_IDLE;
      gap_next   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_next;
      gap_cnt <= gap_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      can_issue <= 1'b0;
      inst      <= '0;
      pc        <= '0;
      has_jump  <= 1'b0;
    end else if (rdy) begin
      if (has_misbranch) begin
        head      <= '0;
        tail      <= '0;
        count     <= '0;
        can_issue <= 1'b0;
      end else begin
        can_issue <= pop || take_fetch;
        if (pop) begin
          inst     <= mem_inst[head];
          pc       <= mem_pc[head];
          has_jump <= mem_jump[head];
          head     <= head + PTR_W'(1);
        end else if (take_fetch) begin
          inst     <= fetch_inst;
          pc       <= fetch_pc;
          has_jump <= fetch_has_jump;
        end
        if (push) tail <= tail + PTR_W'(1);
        if (push && !pop) begin
          count <= count + (PTR_W+1)'(1);
        end else if (pop && !push) begin
          count <= count - (PTR_W+1)'(1);
        end
      end
    end
  end

  // Storage is not reset; head/tail/count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[tail] <= fetch_inst;
      mem_pc[tail]   <= fetch_pc;
      mem_jump[tail] <= fetch_has_jump;
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// tb/tb_issue_ctrl.sv - scoreboard bench for issue_ctrl
module tb_issue_ctrl;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;
  localparam int GAP   = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             rdy;
  logic             has_misbranch;
  logic             fetch_valid;
  logic [31:0]      fetch_inst;
  logic [31:0]      fetch_pc;
  logic             fetch_has_jump;
  logic             fetch_ready;
  logic             rob_avail;
  logic             rs_avail;
  logic             slb_avail;
  logic             can_issue;
  logic [31:0]      inst;
  logic [31:0]      pc;
  logic             has_jump;
  logic [PTR_W:0]   q_count;

  issue_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .has_misbranch(has_misbranch),
    .fetch_valid(fetch_valid), .fetch_inst(fetch_inst), .fetch_pc(fetch_pc),
    .fetch_has_jump(fetch_has_jump), .fetch_ready(fetch_ready),
    .rob_avail(rob_avail), .rs_avail(rs_avail), .slb_avail(slb_avail),
    .can_issue(can_issue), .inst(inst), .pc(pc), .has_jump(has_jump), .q_count(q_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic        edge_rdy = 1'b0;
  logic [64:0] exp_q[$];
  int          pulse_cyc[$];
  logic [64:0] exp_v;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    edge_rdy <= rdy;
  end

  // A strobe counts once: only when the edge that produced it had rdy high.
  always @(negedge clk) begin
    if (can_issue && edge_rdy) begin
      pulse_cyc.push_back(cyc);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_extra: got inst=%h pc=%h jump=%b, want no issue", inst, pc, has_jump);
      end else begin
        exp_v = exp_q.pop_front();
        if ({inst, pc, has_jump} !== exp_v) begin
          n_fail++;
          $display("FAIL sb_data: got %h/%h/%b want %h/%h/%b",
                   inst, pc, has_jump, exp_v[64:33], exp_v[32:1], exp_v[0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no summary, want summary");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic j, input logic expect_issue);
    fetch_valid    = 1'b1;
    fetch_inst     = i;
    fetch_pc       = p;
    fetch_has_jump = j;
    if (expect_issue) exp_q.push_back({i, p, j});
  endtask

  task automatic test_reset();
    rst = 1'b0; rdy = 1'b1; has_misbranch = 1'b0; fetch_valid = 1'b0;
    fetch_inst = '0; fetch_pc = '0; fetch_has_jump = 1'b0;
    rob_avail = 1'b1; rs_avail = 1'b1; slb_avail = 1'b1;
    step(); step();
    n_checks++; if (q_count !== 4'd0) begin n_fail++; $display("FAIL reset_q_count: got %0d want 0", q_count); end
    n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL reset_fetch_ready: got %b want 1", fetch_ready); end
    n_checks++; if (can_issue !== 1'b0) begin n_fail++; $display("FAIL reset_can_issue: got %b want 0", can_issue); end
    n_checks++; if (inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h want 0", inst); end
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", pc); end
    n_checks++; if (has_jump !== 1'b0) begin n_fail++; $display("FAIL reset_has_jump: got %b want 0", has_jump); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic();
    drive(32'h00500093, 32'h0, 1'b0, 1'b1);
    step();
    fetch_valid = 1'b0;
    n_checks++; if (q_count !== 4'd1) begin n_fail++; $display("FAIL basic_queued: got %0d want 1", q_count); end
    n_checks++; if (can_issue !== 1'b0) begin n_fail++; $display("FAIL basic_not_yet: got %b want 0", can_issue); end
    step();
    n_checks++; if (can_issue !== 1'b1) begin n_fail++; $display("FAIL basic_issue: got %b want 1", can_issue); end
    n_checks++; if (inst !== 32'h00500093) begin n_fail++; $display("FAIL basic_inst: got %h want 00500093", inst); end
    n_checks++; if (q_count !== 4'd0) begin n_fail++; $display("FAIL basic_popped: got %0d want 0", q_count); end
    step();
    n_checks++; if (can_issue !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle: got %b want 0", can_issue); end
    step();
  endtask

  task automatic test_back_to_back();
    pulse_cyc.delete();
    drive(32'h00100113, 32'h4, 1'b1, 1'b1);
    step();
    drive(32'h00208193, 32'h8, 1'b0, 1'b1);
    step();
    fetch_valid = 1'b0;
    for (int i = 0; i < 10 && pulse_cyc.size() < 2; i++) step();
    n_checks++;
    if (pulse_cyc.size() != 2) begin
      n_fail++; $display("FAIL b2b_pulses: got %0d want 2", pulse_cyc.size());
    end else if (pulse_cyc[1] - pulse_cyc[0] != GAP) begin
      n_fail++; $display("FAIL b2b_gap: got %0d want %0d", pulse_cyc[1] - pulse_cyc[0], GAP);
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_drained: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_resource_stall();
    logic [31:0] insts [3];
    logic        slb_cls [3];
    insts[0] = 32'h0000A103; slb_cls[0] = 1'b1;
    insts[1] = 32'h0020A023; slb_cls[1] = 1'b1;
    insts[2] = 32'h002081B3; slb_cls[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rob_avail = 1'b1;
      slb_avail = !slb_cls[k];
      rs_avail  = slb_cls[k];
      drive(insts[k], 32'h100 + 32'(k * 4), 1'b0, 1'b1);
      step();
      fetch_valid = 1'b0;
      repeat (3) step();
      n_checks++; if (can_issue !== 1'b0) begin n_fail++; $display("FAIL stall_hold_%0d: got %b want 0", k, can_issue); end
      n_checks++; if (q_count !== 4'd1) begin n_fail++; $display("FAIL stall_count_%0d: got %0d want 1", k, q_count); end
      slb_avail = 1'b1;
      rs_avail  = 1'b1;
      step();
      n_checks++; if (can_issue !== 1'b1) begin n_fail++; $display("FAIL stall_release_%0d: got %b want 1", k, can_issue); end
      n_checks++; if (inst !== insts[k]) begin n_fail++; $display("FAIL stall_inst_%0d: got %h want %h", k, inst, insts[k]); end
      repeat (2) step();
    end
  endtask

  task automatic test_full();
    rob_avail = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(32'h00000013 | (32'(i) << 20), 32'h200 + 32'(i * 4), i[0], i < 8);
      step();
    end
    n_checks++; if (q_count !== 4'd8) begin n_fail++; $display("FAIL full_count: got %0d want 8", q_count); end
    n_checks++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", fetch_ready); end
    rob_avail = 1'b1;
    pulse_cyc.delete();
    step();
    n_checks++; if (q_count !== 4'd7) begin n_fail++; $display("FAIL full_pop_no_push: got %0d want 7", q_count); end
    n_checks++; if (can_issue !== 1'b1) begin n_fail++; $display("FAIL full_first_issue: got %b want 1", can_issue); end
    fetch_valid = 1'b0;
    for (int i = 0; i < 40 && pulse_cyc.size() < 8; i++) step();
    n_checks++;
    if (pulse_cyc.size() != 8) begin
      n_fail++; $display("FAIL full_pulses: got %0d want 8", pulse_cyc.size());
    end else begin
      for (int i = 1; i < 8; i++) begin
        n_checks++;
        if (pulse_cyc[i] - pulse_cyc[i-1] != GAP) begin
          n_fail++; $display("FAIL full_gap_%0d: got %0d want %0d", i, pulse_cyc[i] - pulse_cyc[i-1], GAP);
        end
      end
    end
    n_checks++; if (q_count !== 4'd0) begin n_fail++; $display("FAIL full_empty: got %0d want 0", q_count); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL full_drained: got %0d want 0", exp_q.size()); end
    step();
  endtask

  task automatic test_misbranch();
    rob_avail = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(32'h00100093 + (32'(i) << 20), 32'h300 + 32'(i * 4), 1'b0, 1'b0);
      step();
    end
    n_checks++; if (q_count !== 4'd5) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 5", q_count); end
    drive(32'h00300093, 32'h320, 1'b1, 1'b0);
    has_misbranch = 1'b1;
    step();
    has_misbranch = 1'b0;
    fetch_valid   = 1'b0;
    n_checks++; if (q_count !== 4'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", q_count); end
    n_checks++; if (can_issue !== 1'b0) begin n_fail++; $display("FAIL flush_can_issue: got %b want 0", can_issue); end
    n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b want 1", fetch_ready); end
    rob_avail = 1'b1;
    pulse_cyc.delete();
    repeat (4) step();
    n_checks++; if (pulse_cyc.size() != 0) begin n_fail++; $display("FAIL flush_no_issue: got %0d want 0", pulse_cyc.size()); end
    n_checks++; if (q_count !== 4'd0) begin n_fail++; $display("FAIL flush_stays_empty: got %0d want 0", q_count); end
  endtask

  task automatic test_rdy_hold();
    pulse_cyc.delete();
    drive(32'h00A00093, 32'h400, 1'b0, 1'b1);
    step();
    drive(32'h01400113, 32'h404, 1'b1, 1'b1);
    step();
    fetch_valid = 1'b0;
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (can_issue !== 1'b1) begin n_fail++; $display("FAIL rdy_hold_issue_%0d: got %b want 1", i, can_issue); end
      n_checks++; if (q_count !== 4'd1) begin n_fail++; $display("FAIL rdy_hold_count_%0d: got %0d want 1", i, q_count); end
    end
    rdy = 1'b1;
    step();
    n_checks++; if (can_issue !== 1'b0) begin n_fail++; $display("FAIL rdy_gap: got %b want 0", can_issue); end
    n_checks++; if (q_count !== 4'd1) begin n_fail++; $display("FAIL rdy_gap_count: got %0d want 1", q_count); end
    step();
    n_checks++; if (can_issue !== 1'b1) begin n_fail++; $display("FAIL rdy_next_issue: got %b want 1", can_issue); end
    n_checks++; if (inst !== 32'h01400113) begin n_fail++; $display("FAIL rdy_next_inst: got %h want 01400113", inst); end
    n_checks++; if (q_count !== 4'd0) begin n_fail++; $display("FAIL rdy_next_count: got %0d want 0", q_count); end
    step();
    n_checks++; if (pulse_cyc.size() != 2) begin n_fail++; $display("FAIL rdy_pulse_count: got %0d want 2", pulse_cyc.size()); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rdy_drained: got %0d want 0", exp_q.size()); end
    step();
  endtask

  task automatic test_async_reset();
    drive(32'h00C00093, 32'h500, 1'b1, 1'b1);
    step();
    drive(32'h00D00093, 32'h504, 1'b0, 1'b0);
    step();
    fetch_valid = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_checks++; if (can_issue !== 1'b0) begin n_fail++; $display("FAIL areset_can_issue: got %b want 0", can_issue); end
    n_checks++; if (inst !== 32'h0) begin n_fail++; $display("FAIL areset_inst: got %h want 0", inst); end
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL areset_pc: got %h want 0", pc); end
    n_checks++; if (has_jump !== 1'b0) begin n_fail++; $display("FAIL areset_has_jump: got %b want 0", has_jump); end
    n_checks++; if (q_count !== 4'd0) begin n_fail++; $display("FAIL areset_count: got %0d want 0", q_count); end
    n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL areset_ready: got %b want 1", fetch_ready); end
    #1;
    rst = 1'b1;
    step();
    drive(32'h00F00213, 32'h600, 1'b0, 1'b1);
    step();
    fetch_valid = 1'b0;
    n_checks++; if (q_count !== 4'd1) begin n_fail++; $display("FAIL restart_count: got %0d want 1", q_count); end
    step();
    n_checks++; if (can_issue !== 1'b1) begin n_fail++; $display("FAIL restart_issue: got %b want 1", can_issue); end
    n_checks++; if (inst !== 32'h00F00213) begin n_fail++; $display("FAIL restart_inst: got %h want 00F00213", inst); end
    step();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL restart_drained: got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_resource_stall();
    test_full();
    test_misbranch();
    test_rdy_hold();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
